// File: rtl/mem_err_gen_if.sv
// Bus bundle for mem_err_gen: read strobe, memory handshake, data words and error flags.
// master = requester/memory side, slave = the checker block.
interface mem_err_gen_if #(
    parameter int unsigned DATA_W = 13
);
    logic              rd_stb;
    logic [1:0]        msel;
    logic              duplex;
    logic              mem_ack;
    logic [DATA_W:0]   da;
    logic [DATA_W:0]   db;
    logic              ed_clr;
    logic              mem_req;
    logic [7:0]        edx;
    logic [7:0]        edy;
    logic              eap;
    logic              ebp;
    logic [DATA_W-1:0] dout;
    logic              dvalid;
    logic              busy;

    modport master (
        output rd_stb, msel, duplex, mem_ack, da, db, ed_clr,
        input  mem_req, edx, edy, eap, ebp, dout, dvalid, busy
    );

    modport slave (
        input  rd_stb, msel, duplex, mem_ack, da, db, ed_clr,
        output mem_req, edx, edy, eap, ebp, dout, dvalid, busy
    );
endinterface

// File: rtl/mem_err_gen.sv
// Duplex memory read checker: fetches a word pair, checks odd parity, re-reads once on error,
// keeps sticky first-check/recheck flags per module pair and side, and delivers the good data.
module mem_err_gen #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned TMO    = 15
) (
    input logic          clk,
    input logic          rst,
    mem_err_gen_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ1 = 3'd1;
    localparam logic [2:0] CHK1 = 3'd2;
    localparam logic [2:0] REQ2 = 3'd3;
    localparam logic [2:0] CHK2 = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam int unsigned WORD_W   = DATA_W + 1;
    localparam logic [3:0]  TMO_LAST = 4'(TMO - 1);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [3:0]        tmo_cnt;
    logic [1:0]        msel_l;
    logic              duplex_l;
    logic [WORD_W-1:0] word_a;
    logic [WORD_W-1:0] word_b;
    logic [7:0]        edx;
    logic [7:0]        edy;
    logic [7:0]        edx_nx;
    logic [7:0]        edy_nx;
    logic [DATA_W-1:0] dout;
    logic [DATA_W-1:0] dout_sel;
    logic              dout_load;
    logic              err_a;
    logic              err_b;
    logic              in_req;
    logic              timeout;
    logic [7:0]        mask_a;
    logic [7:0]        mask_b;

    // Odd parity: a word whose bits XOR to 0 is bad; side B only counts in duplex reads.
    assign err_a   = ~(^word_a);
    assign err_b   = duplex_l & ~(^word_b);
    assign in_req  = (state == REQ1) || (state == REQ2);
    assign timeout = in_req && !bus.mem_ack && (tmo_cnt == TMO_LAST);
    assign mask_a  = 8'b01 << {msel_l, 1'b0};
    assign mask_b  = duplex_l ? (8'b10 << {msel_l, 1'b0}) : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.rd_stb) state_nx = REQ1;
            REQ1: begin
                if (bus.mem_ack)  state_nx = CHK1;
                else if (timeout) state_nx = DONE;
            end
            CHK1: state_nx = (err_a || err_b) ? REQ2 : DONE;
            REQ2: begin
                if (bus.mem_ack)  state_nx = CHK2;
                else if (timeout) state_nx = DONE;
            end
            CHK2:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Clear first, then OR in this cycle's sets so a same-cycle set survives ed_clr.
    always_comb begin
        edx_nx = bus.ed_clr ? '0 : edx;
        edy_nx = bus.ed_clr ? '0 : edy;
        if (state == CHK1) begin
            if (err_a) edx_nx = edx_nx | mask_a;
            if (err_b) edx_nx = edx_nx | mask_b;
        end
        if (state == CHK2) begin
            if (err_a) edy_nx = edy_nx | mask_a;
            if (err_b) edy_nx = edy_nx | mask_b;
        end
        if (timeout) begin
            edx_nx = edx_nx | mask_a | mask_b;
            edy_nx = edy_nx | mask_a | mask_b;
        end
    end

    always_comb begin
        dout_sel = word_a[DATA_W-1:0];
        if (err_a && duplex_l && !err_b)
            dout_sel = word_b[DATA_W-1:0];
        dout_load = ((state == CHK1) && !(err_a || err_b)) || (state == CHK2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            msel_l   <= '0;
            duplex_l <= 1'b0;
            word_a   <= '0;
            word_b   <= '0;
            edx      <= '0;
            edy      <= '0;
            dout     <= '0;
        end else begin
            state <= state_nx;
            edx   <= edx_nx;
            edy   <= edy_nx;
            if (in_req && !bus.mem_ack && !timeout)
                tmo_cnt <= tmo_cnt + 4'd1;
            else
                tmo_cnt <= '0;
            if ((state == IDLE) && bus.rd_stb) begin
                msel_l   <= bus.msel;
                duplex_l <= bus.duplex;
            end
            if (in_req && bus.mem_ack) begin
                word_a <= bus.da;
                word_b <= bus.db;
            end
            if (dout_load)
                dout <= dout_sel;
        end
    end

    assign bus.mem_req = in_req;
    assign bus.edx     = edx;
    assign bus.edy     = edy;
    assign bus.eap     = (state == CHK1) && err_a;
    assign bus.ebp     = (state == CHK1) && err_b;
    assign bus.dout    = dout;
    assign bus.dvalid  = (state == DONE);
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_mem_err_gen.sv
// Self-checking bench for mem_err_gen: directed scenarios plus random transactions
// compared against a transaction-level model of the parity/re-read/flag rules.
module tb_mem_err_gen;
    localparam int unsigned DATA_W = 13;
    localparam int unsigned TMO    = 15;

    typedef logic [DATA_W:0]   word_t;
    typedef logic [DATA_W-1:0] data_t;

    logic clk = 1'b0;
    logic rst;

    mem_err_gen_if #(.DATA_W(DATA_W)) bus ();

    mem_err_gen #(.DATA_W(DATA_W), .TMO(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mx;
    logic [7:0] my;
    data_t      md;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic word_t mk(input data_t d, input bit good);
        return good ? {~^d, d} : {^d, d};
    endfunction

    function automatic bit bad(input word_t w);
        return (^w) == 1'b0;
    endfunction

    function automatic logic [7:0] side_bit(input logic [1:0] ms, input int side);
        return 8'(1) << (2 * int'(ms) + side);
    endfunction

    task automatic clr_flags();
        bus.ed_clr = 1'b1;
        tick();
        bus.ed_clr = 1'b0;
        mx = '0;
        my = '0;
        chk("ed_clr_edx", bus.edx, 0);
        chk("ed_clr_edy", bus.edy, 0);
    endtask

    // Entered in the first cycle of a request phase; leaves in the cycle after it ends.
    task automatic req_phase(input int dly, input bit tmo, input word_t a, input word_t b,
                             input string nm);
        int n;
        n = tmo ? int'(TMO) : dly;
        for (int i = 0; i < n; i++) begin
            chk({nm, "_req_hold"}, bus.mem_req, 1);
            if (i == 0) begin
                bus.rd_stb = 1'b1;
                bus.msel   = 2'($urandom);
                bus.duplex = 1'($urandom);
            end
            tick();
            bus.rd_stb = 1'b0;
        end
        if (!tmo) begin
            chk({nm, "_req_at_ack"}, bus.mem_req, 1);
            bus.mem_ack = 1'b1;
            bus.da      = a;
            bus.db      = b;
            tick();
            bus.mem_ack = 1'b0;
            bus.da      = word_t'($urandom);
            bus.db      = word_t'($urandom);
        end
        chk({nm, "_req_drop"}, bus.mem_req, 0);
    endtask

    task automatic txn(input logic [1:0] ms, input bit dup,
                       input word_t a1, input word_t b1, input word_t a2, input word_t b2,
                       input int d1, input int d2, input bit t1, input bit t2, input bit clr1);
        logic [7:0] act;
        logic [7:0] ma;
        logic [7:0] mb;
        bit ea1, eb1, ea2, eb2;
        ma  = side_bit(ms, 0);
        mb  = dup ? side_bit(ms, 1) : 8'h00;
        act = ma | mb;
        ea1 = bad(a1);
        eb1 = dup && bad(b1);

        bus.rd_stb = 1'b1;
        bus.msel   = ms;
        bus.duplex = dup;
        tick();
        bus.rd_stb = 1'b0;
        chk("req1_rise", bus.mem_req, 1);
        chk("busy_req1", bus.busy, 1);
        req_phase(d1, t1, a1, b1, "p1");

        if (t1) begin
            mx = mx | act;
            my = my | act;
        end else begin
            chk("eap_chk1", bus.eap, 32'(ea1));
            chk("ebp_chk1", bus.ebp, 32'(eb1));
            if (clr1) begin
                bus.ed_clr = 1'b1;
                mx = '0;
                my = '0;
            end
            if (ea1) mx = mx | ma;
            if (eb1) mx = mx | mb;
            tick();
            bus.ed_clr = 1'b0;
            if (ea1 || eb1) begin
                chk("req2_rise", bus.mem_req, 1);
                req_phase(d2, t2, a2, b2, "p2");
                if (t2) begin
                    mx = mx | act;
                    my = my | act;
                end else begin
                    ea2 = bad(a2);
                    eb2 = dup && bad(b2);
                    chk("eap_chk2", bus.eap, 0);
                    chk("ebp_chk2", bus.ebp, 0);
                    if (ea2) my = my | ma;
                    if (eb2) my = my | mb;
                    md = (!ea2 || !(dup && !eb2)) ? a2[DATA_W-1:0] : b2[DATA_W-1:0];
                    tick();
                end
            end else begin
                md = a1[DATA_W-1:0];
            end
        end

        chk("dvalid_done", bus.dvalid, 1);
        chk("dout_done", bus.dout, 32'(md));
        chk("edx_done", bus.edx, 32'(mx));
        chk("edy_done", bus.edy, 32'(my));
        tick();
        chk("dvalid_low", bus.dvalid, 0);
        chk("busy_idle", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t a1, b1, a2, b2;
        data_t d;
        bus.rd_stb  = 1'b0;
        bus.msel    = '0;
        bus.duplex  = 1'b0;
        bus.mem_ack = 1'b0;
        bus.da      = '0;
        bus.db      = '0;
        bus.ed_clr  = 1'b0;
        mx = '0;
        my = '0;
        md = '0;

        rst = 1'b1;
        tick();
        bus.rd_stb = 1'b1;
        tick();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_edx", bus.edx, 0);
        chk("rst_edy", bus.edy, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_dvalid", bus.dvalid, 0);
        chk("rst_eap_ebp", {bus.eap, bus.ebp}, 0);
        bus.rd_stb = 1'b0;
        rst = 1'b0;
        tick();

        // Clean duplex read on pair TT.
        txn(2'd1, 1'b1, mk(13'h0001, 1), mk(13'h0001, 1), '0, '0, 2, 0, 0, 0, 0);

        // Side A bad on both reads, B good: re-read and deliver B.
        clr_flags();
        d = data_t'($urandom);
        txn(2'd2, 1'b1, mk(d, 0), mk(13'h0003, 1), mk(d, 0), mk(13'h0003, 1), 1, 3, 0, 0, 0);
        chk("edx_044", bus.edx, 32'h10);

        // Simplex: bad B must be ignored; re-read A is good.
        clr_flags();
        a2 = mk(13'h0ABC, 1);
        txn(2'd0, 1'b0, mk(13'h0555, 0), mk(13'h0011, 0), a2, mk(13'h0022, 0), 0, 2, 0, 0, 0);
        chk("edx_045", bus.edx, 32'h01);
        chk("dout_045", bus.dout, 32'h0ABC);

        // No acknowledge at all: timeout flags both sides of pair SS, data held.
        clr_flags();
        txn(2'd3, 1'b1, '0, '0, '0, '0, 0, 0, 1, 0, 0);
        chk("edx_046", bus.edx, 32'hC0);
        chk("dout_046", bus.dout, 32'h0ABC);

        // ed_clr coincident with a first-check error: the new flag survives.
        txn(2'd1, 1'b0, mk(13'h0100, 0), '0, mk(13'h0100, 1), '0, 0, 0, 0, 0, 1);
        chk("edx_047", bus.edx, 32'h04);

        // Stray acknowledge while idle is ignored.
        bus.mem_ack = 1'b1;
        bus.da      = mk(13'h1FFF, 0);
        tick();
        bus.mem_ack = 1'b0;
        chk("stray_ack_busy", bus.busy, 0);
        chk("stray_ack_req", bus.mem_req, 0);
        tick();
        chk("stray_ack_edx", bus.edx, 32'(mx));

        // Reset while in REQ2 aborts immediately.
        bus.rd_stb = 1'b1;
        bus.msel   = 2'd1;
        bus.duplex = 1'b0;
        tick();
        bus.rd_stb  = 1'b0;
        bus.mem_ack = 1'b1;
        bus.da      = mk(13'h0042, 0);
        tick();
        bus.mem_ack = 1'b0;
        tick();
        chk("abort_in_req2", bus.mem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_req", bus.mem_req, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_edx", bus.edx, 0);
        chk("abort_dout", bus.dout, 0);
        tick();
        chk("abort_dvalid", bus.dvalid, 0);
        mx = '0;
        my = '0;
        md = '0;
        rst = 1'b0;
        tick();
        chk("abort_dvalid_after", bus.dvalid, 0);
        txn(2'd2, 1'b1, mk(13'h0777, 1), mk(13'h0001, 0), '0, '0, 1, 0, 0, 0, 0);

        // Random transactions.
        for (int k = 0; k < 40; k++) begin
            logic [1:0] ms;
            bit dup, t1, t2;
            ms  = 2'($urandom_range(0, 3));
            dup = 1'($urandom);
            a1  = mk(data_t'($urandom), $urandom_range(0, 9) < 6);
            b1  = mk(data_t'($urandom), $urandom_range(0, 9) < 6);
            a2  = mk(data_t'($urandom), $urandom_range(0, 9) < 5);
            b2  = mk(data_t'($urandom), $urandom_range(0, 9) < 5);
            t1  = ($urandom_range(0, 9) == 0);
            t2  = ($urandom_range(0, 7) == 0);
            txn(ms, dup, a1, b1, a2, b2, $urandom_range(0, 4), $urandom_range(0, 4),
                t1, t2, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 7) == 0) clr_flags();
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_err_gen.md
MEM_ERR_GEN -- requirements
Module: mem_err_gen

Interface
REQ-001 Parameter DATA_W, default 13, SHALL set data bits per syllable; each memory word is DATA_W data bits plus 1 parity bit (MSB).
REQ-002 Parameter TMO, default 15, SHALL set the MEM_ACK timeout in CLK cycles, counted from MEM_REQ rise.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; both are listed first below.
REQ-004 CLK  in  1  system clock; all state changes on the rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 RD_STB  in  1  single-cycle request to fetch and check one word.
REQ-007 MSEL  in  2  module pair select: 0=ZO, 1=TT, 2=FF, 3=SS.
REQ-008 DUPLEX  in  1  side B is active for this read.
REQ-009 MEM_ACK  in  1  memory data valid on DA and DB.
REQ-010 DA  in  DATA_W+1  side A word.
REQ-011 DB  in  DATA_W+1  side B word.
REQ-012 ED_CLR  in  1  clears all EDX and EDY bits.
REQ-013 MEM_REQ  out  1  read request to memory.
REQ-014 EDX  out  8  first-check error flags; bit 2k = pair k side A, bit 2k+1 = pair k side B.
REQ-015 EDY  out  8  recheck error flags; same bit mapping as EDX.
REQ-016 EAP  out  1  one-cycle pulse: side A parity error on the first check.
REQ-017 EBP  out  1  one-cycle pulse: side B parity error on the first check.
REQ-018 DOUT  out  DATA_W  selected good data.
REQ-019 DVALID  out  1  one-cycle pulse: DOUT is valid.
REQ-020 BUSY  out  1  high in every state except IDLE.

Function
REQ-021 Parity SHALL be odd across all DATA_W+1 bits; a word is in error when the XOR of all its bits is 0.
REQ-022 The FSM SHALL have exactly these states: IDLE, REQ1, CHK1, REQ2, CHK2, DONE.
REQ-023 IDLE: on RD_STB, the block SHALL latch MSEL and DUPLEX and enter REQ1; RD_STB is ignored while BUSY.
REQ-024 REQ1/REQ2: MEM_REQ SHALL be high for the whole state.
REQ-025 REQ1/REQ2: on MEM_ACK, DA and DB SHALL be captured and the FSM SHALL go to CHK1 or CHK2 respectively, with MEM_REQ low on the following cycle.
REQ-026 CHK1: a side A parity error SHALL set EDX[2k] and pulse EAP.
REQ-027 CHK1: a side B parity error with DUPLEX=1 SHALL set EDX[2k+1] and pulse EBP.
REQ-028 CHK1: if any error was flagged, the next state SHALL be REQ2; otherwise DONE.
REQ-029 CHK2: each active side whose re-read word has a parity error SHALL set its EDY bit; the next state SHALL be DONE.
REQ-030 Side B SHALL never be checked or flagged when DUPLEX=0.
REQ-031 DONE: DOUT SHALL be the latest A data if A passed its latest check; else the latest B data if DUPLEX=1 and B passed; else the latest A data.
REQ-032 DONE: DVALID SHALL pulse for one cycle, then the FSM SHALL return to IDLE.
REQ-033 Latency with no error: MEM_REQ rises the cycle after RD_STB; with MEM_ACK in cycle a, DVALID is in cycle a+2.
REQ-034 Timeout: a 4-bit counter SHALL run while in REQ1 or REQ2.
REQ-035 Timeout: when TMO cycles pass without MEM_ACK, EDX and EDY SHALL both be set for every active side.
REQ-036 Timeout: MEM_REQ SHALL drop and the FSM SHALL go to DONE; DOUT is then held at its previous value.
REQ-037 EDX and EDY bits SHALL be sticky until ED_CLR or RST.
REQ-038 If ED_CLR and a set occur in the same cycle, the set SHALL win for that bit.
REQ-039 MEM_ACK outside REQ1/REQ2 SHALL be ignored.

Reset
REQ-040 While RST is high, the FSM SHALL be in IDLE and the timeout counter SHALL be 0.
REQ-041 While RST is high, MEM_REQ, EDX, EDY, EAP, EBP, DOUT, DVALID and BUSY SHALL all be 0.
REQ-042 RST asserted during a transaction SHALL abort it immediately, with no DVALID pulse and no flag set.

Verification
REQ-043 MSEL=1, DUPLEX=1, DA=DB=0x0001, MEM_ACK 2 cycles after MEM_REQ -> DVALID 2 cycles after MEM_ACK, DOUT=0x0001, EDX=EDY=0.
REQ-044 MSEL=2, DUPLEX=1, DA bad parity both reads, DB good 0x0003 -> EAP pulse, EDX=0x10, EDY=0x10, DOUT=0x0003, two MEM_REQ phases.
REQ-045 MSEL=0, DUPLEX=0, DA bad first read, good on re-read, DB bad -> EDX=0x01, EDY=0x00, EBP stays 0, DOUT = re-read A data.
REQ-046 MSEL=3, DUPLEX=1, no MEM_ACK -> MEM_REQ drops after 15 cycles, EDX=EDY=0xC0, DVALID pulse with DOUT unchanged.
REQ-047 Flags set, then ED_CLR in the same cycle as a CHK1 error on pair 1 side A -> EDX=0x04 only.
REQ-048 RST asserted while in REQ2 -> all outputs 0 next edge, no DVALID; a new RD_STB is accepted after release.
